flu_qdr_reader: RTL and testbench
=================================

Name: flu_qdr_reader

Overview:
- Read side of the FLU-over-QDR frame buffer: streams words that the FLU writer stored in the QDR ring back out as a FrameLinkUnaligned (FLU) stream.
- Compares its issue pointer with the writer's WR_PTR and issues QDR read requests under a credit limit.
- Captures in-order read responses into a local FIFO and drives TX.
- Returns RD_PTR to the writer so the writer can compute ring free space.

Parameters:
- DATA_WIDTH, 512: FLU data width.
- SOP_POS_WIDTH, 3: FLU SOP_POS width.
- EOP_POS_WIDTH, 6: FLU EOP_POS width.
- ADDR_WIDTH, 20: QDR word address width; the ring holds 2^ADDR_WIDTH words.
- BUF_ITEMS, 16: local response FIFO depth and credit limit. Must be a power of 2 and at least the QDR read latency + 2.

Ports:
- APP_CLK, in, 1: clock.
- APP_RST, in, 1: synchronous active-high reset.
- WR_PTR, in, ADDR_WIDTH+1: writer pointer, i.e. the next free word. The MSB is the wrap bit.
- RD_PTR, out, ADDR_WIDTH+1: released pointer, i.e. the first word not yet sent on TX.
- QDR_RD_REQ, out, 1: read request.
- QDR_RD_ADDR, out, ADDR_WIDTH: read address.
- QDR_RD_RDY, in, 1: request accepted when high together with REQ.
- QDR_RD_DATA, in, W: stored word, where W = DATA_WIDTH+SOP_POS_WIDTH+EOP_POS_WIDTH+2.
- QDR_RD_VALID, in, 1: response valid. Responses arrive in request order.
- TX_DATA, out, DATA_WIDTH: FLU data.
- TX_SOP_POS, out, SOP_POS_WIDTH: FLU SOP position.
- TX_EOP_POS, out, EOP_POS_WIDTH: FLU EOP position.
- TX_SOP, out, 1: FLU start of packet.
- TX_EOP, out, 1: FLU end of packet.
- TX_SRC_RDY, out, 1: FLU source ready.
- TX_DST_RDY, in, 1: FLU destination ready.

Behaviour:
- Stored word layout, LSB first: EOP, SOP, EOP_POS, SOP_POS, DATA. Output fields are bit-exact slices of the stored word.
- Reset: RD_PTR=0, internal issue pointer IP=0, credit CNT=0, FIFO empty, QDR_RD_REQ=0, TX_SRC_RDY=0. QDR_RD_VALID is ignored while APP_RST=1. The QDR read path shares APP_RST.
- Ring empty: when IP == WR_PTR, all ADDR_WIDTH+1 bits compared. IP and RD_PTR wrap naturally modulo 2^(ADDR_WIDTH+1).
- Request rule: QDR_RD_REQ = not empty AND CNT < BUF_ITEMS. QDR_RD_ADDR = IP[ADDR_WIDTH-1:0].
  - QDR_RD_REQ may assert in the cycle a WR_PTR change makes the ring non-empty (combinational from registers and WR_PTR).
  - REQ and ADDR stay stable until RDY.
  - On REQ & RDY: IP increments.
- Credit CNT (0..BUF_ITEMS) counts in-flight plus buffered words:
  - +1 on an accepted request.
  - -1 on a TX transfer (TX_SRC_RDY & TX_DST_RDY).
  - Both in the same cycle: unchanged.
  - This guarantees the FIFO never overflows, so TX back-pressure never stalls QDR responses.
- Response capture: QDR_RD_VALID writes QDR_RD_DATA into the FIFO.
  - TX_SRC_RDY asserts the cycle after the first write into an empty FIFO (1-cycle latency, registered FWFT head).
  - FIFO write while the FIFO is full is a protocol violation; simulation assertion only.
- TX: TX_SRC_RDY = FIFO not empty; outputs show the head word.
  - Fields hold stable while SRC_RDY & !DST_RDY.
  - Simultaneous FIFO read and write sustain one word per cycle.
- RD_PTR increments by 1 per TX transfer. Words are released only after leaving TX, never at request time.
- Throughput: with RDY and DST_RDY held high and the ring non-empty, one word per cycle steady state.
- The block does not interpret SOP/EOP; frame boundaries pass through unchanged.

Test Plan:
- Reset, WR_PTR=0 -> REQ=0, TX_SRC_RDY=0, RD_PTR=0 for 20 cycles.
- Writer-side model stores a 3-word frame (SOP=1,SOP_POS=2 / mid / EOP=1,EOP_POS=37), WR_PTR=3, RDY=1, memory latency 6 -> addresses 0,1,2 requested in consecutive cycles. TX shows the three words bit-exact in order, first TX_SRC_RDY 7 cycles after the first request. RD_PTR ends at 3.
- TX_DST_RDY=0, WR_PTR=40 -> exactly BUF_ITEMS=16 requests, then REQ=0. FIFO holds 16 words. Release DST_RDY -> the remaining 24 words are requested and delivered, and RD_PTR=40.
- Wrap: ADDR_WIDTH=4, prefill pointers to 14, WR_PTR=18 (wrap bit set) -> addresses 14,15,0,1. RD_PTR reaches 18 with MSB=1; ring reports empty afterwards.
- Random RDY (50%), random DST_RDY (30%), 1000 random frames through a scoreboard -> no loss, reorder or corruption. CNT never exceeds 16 and the FIFO overflow assertion never fires.
- APP_RST pulse with 5 reads in flight and FIFO holding 4 words -> after reset all outputs are at reset values. VALID pulses during reset are ignored. New traffic from pointer 0 is correct.

Source files
------------

// File: rtl/flu_qdr_reader.sv
// -----------------------------------------------------------------------------
// flu_qdr_reader
//
// Read side of the FLU-over-QDR frame buffer. Words that the FLU writer stored
// in the QDR ring are fetched in order, captured in a small local FIFO and
// replayed on a FrameLinkUnaligned TX stream.
//
// Flow:
//   - The issue pointer is compared against the writer's WR_PTR. While the
//     ring holds unread words and fewer than BUF_ITEMS words are in flight or
//     buffered, a QDR read request is presented.
//   - In-order read responses are written into the local FIFO. The credit
//     counter bounds in-flight plus buffered words, so the FIFO can never
//     overflow and TX back-pressure never has to stall the QDR read path.
//   - RD_PTR advances only when a word actually leaves on TX, so the writer
//     never reuses a slot whose contents have not been delivered.
//
// Ports:
//   APP_CLK, APP_RST        clock, synchronous active-high reset
//   WR_PTR                  writer pointer (next free word, MSB = wrap bit)
//   RD_PTR                  released pointer (first word not yet sent on TX)
//   QDR_RD_REQ/ADDR/RDY     QDR read request handshake
//   QDR_RD_DATA/VALID       in-order QDR read responses
//   TX_*                    FLU output stream
//
// Stored word layout, LSB first: EOP, SOP, EOP_POS, SOP_POS, DATA.
// -----------------------------------------------------------------------------

// Protocol checker: response FIFO overflow and credit bound.
module flu_qdr_reader_chk #(
    parameter int BUF_ITEMS = 16,
    parameter int CNT_W     = 5
) (
    input logic             clk,
    input logic             rst,
    input logic             wr,
    input logic             rd,
    input logic [CNT_W-1:0] fill,
    input logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_ITEMS);

    // A response arriving into a full FIFO with no read in the same cycle would be lost.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr && (fill == FULL) && !rd));

    // Credit counter must never exceed the FIFO depth.
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (cnt <= FULL));
endmodule

module flu_qdr_reader #(
    parameter int DATA_WIDTH    = 512,
    parameter int SOP_POS_WIDTH = 3,
    parameter int EOP_POS_WIDTH = 6,
    parameter int ADDR_WIDTH    = 20,
    parameter int BUF_ITEMS     = 16
) (
    input  logic                                              APP_CLK,
    input  logic                                              APP_RST,
    input  logic [ADDR_WIDTH:0]                               WR_PTR,
    output logic [ADDR_WIDTH:0]                               RD_PTR,
    output logic                                              QDR_RD_REQ,
    output logic [ADDR_WIDTH-1:0]                             QDR_RD_ADDR,
    input  logic                                              QDR_RD_RDY,
    input  logic [DATA_WIDTH+SOP_POS_WIDTH+EOP_POS_WIDTH+1:0] QDR_RD_DATA,
    input  logic                                              QDR_RD_VALID,
    output logic [DATA_WIDTH-1:0]                             TX_DATA,
    output logic [SOP_POS_WIDTH-1:0]                          TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0]                          TX_EOP_POS,
    output logic                                              TX_SOP,
    output logic                                              TX_EOP,
    output logic                                              TX_SRC_RDY,
    input  logic                                              TX_DST_RDY
);
    localparam int WORD_W = DATA_WIDTH + SOP_POS_WIDTH + EOP_POS_WIDTH + 2;
    localparam int PTR_W  = ADDR_WIDTH + 1;
    localparam int BUF_AW = $clog2(BUF_ITEMS);
    localparam int CNT_W  = BUF_AW + 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUF_ITEMS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [BUF_AW-1:0] IDX_ONE   = BUF_AW'(1);
    localparam logic [BUF_AW-1:0] IDX_ZERO  = {BUF_AW{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

    // Pointers and credit
    logic [PTR_W-1:0]  ip_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;

    // Response FIFO: backing store plus a registered head word
    logic [WORD_W-1:0] mem_r [BUF_ITEMS];
    logic [BUF_AW-1:0] mem_wr_r;
    logic [BUF_AW-1:0] mem_rd_r;
    logic [CNT_W-1:0]  mem_cnt_r;
    logic [WORD_W-1:0] head_r;
    logic              head_valid_r;

    logic              ring_empty_s;
    logic              req_s;
    logic              accept_s;
    logic              tx_fire_s;
    logic              wr_s;
    logic              head_load_s;
    logic              mem_pop_s;
    logic              bypass_s;
    logic              mem_push_s;
    logic [CNT_W-1:0]  fill_s;

    // Request qualification and FIFO steering.
    always_comb begin
        ring_empty_s = (ip_r == WR_PTR);
        req_s        = !ring_empty_s && (cnt_r < CNT_FULL);
        accept_s     = req_s && QDR_RD_RDY;
        tx_fire_s    = head_valid_r && TX_DST_RDY;
        wr_s         = QDR_RD_VALID && !APP_RST;
        // Head register takes a new word when empty or when its word leaves this cycle.
        head_load_s  = !head_valid_r || tx_fire_s;
        mem_pop_s    = head_load_s && (mem_cnt_r != CNT_ZERO);
        // With nothing queued behind the head, a fresh response goes straight to the head.
        bypass_s     = head_load_s && (mem_cnt_r == CNT_ZERO) && wr_s;
        mem_push_s   = wr_s && !bypass_s;
        fill_s       = mem_cnt_r + {{(CNT_W-1){1'b0}}, head_valid_r};
    end

    // Issue pointer, release pointer and credit counter.
    always_ff @(posedge APP_CLK) begin
        if (APP_RST) begin
            ip_r     <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                ip_r <= ip_r + PTR_ONE;
            end
            if (tx_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, tx_fire_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // FIFO pointers, occupancy and head register.
    always_ff @(posedge APP_CLK) begin
        if (APP_RST) begin
            mem_wr_r     <= IDX_ZERO;
            mem_rd_r     <= IDX_ZERO;
            mem_cnt_r    <= CNT_ZERO;
            head_r       <= WORD_ZERO;
            head_valid_r <= 1'b0;
        end else begin
            if (mem_push_s) begin
                mem_wr_r <= mem_wr_r + IDX_ONE;
            end
            if (mem_pop_s) begin
                mem_rd_r <= mem_rd_r + IDX_ONE;
            end
            case ({mem_push_s, mem_pop_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_ONE;
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_ONE;
                default: mem_cnt_r <= mem_cnt_r;
            endcase
            if (mem_pop_s) begin
                head_r       <= mem_r[mem_rd_r];
                head_valid_r <= 1'b1;
            end else if (bypass_s) begin
                head_r       <= QDR_RD_DATA;
                head_valid_r <= 1'b1;
            end else if (head_load_s) begin
                head_valid_r <= 1'b0;
            end
        end
    end

    // FIFO backing store (data only, no reset needed).
    always_ff @(posedge APP_CLK) begin
        if (mem_push_s) begin
            mem_r[mem_wr_r] <= QDR_RD_DATA;
        end
    end

    assign QDR_RD_REQ  = req_s;
    assign QDR_RD_ADDR = ip_r[ADDR_WIDTH-1:0];
    assign RD_PTR      = rd_ptr_r;

    assign TX_SRC_RDY  = head_valid_r;
    assign TX_EOP      = head_r[0];
    assign TX_SOP      = head_r[1];
    assign TX_EOP_POS  = head_r[2 +: EOP_POS_WIDTH];
    assign TX_SOP_POS  = head_r[2 + EOP_POS_WIDTH +: SOP_POS_WIDTH];
    assign TX_DATA     = head_r[2 + EOP_POS_WIDTH + SOP_POS_WIDTH +: DATA_WIDTH];

    flu_qdr_reader_chk #(
        .BUF_ITEMS (BUF_ITEMS),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk  (APP_CLK),
        .rst  (APP_RST),
        .wr   (wr_s),
        .rd   (tx_fire_s),
        .fill (fill_s),
        .cnt  (cnt_r)
    );
endmodule

// File: tb/tb_flu_qdr_reader.sv
// -----------------------------------------------------------------------------
// tb_flu_qdr_reader
//
// Directed bench for flu_qdr_reader. A negedge process models the QDR memory
// (fixed 6-cycle read latency) and a TX scoreboard that checks every word
// leaving the block against the writer-side expected queue. The main process
// runs a table of per-cycle vectors for a single 3-word frame, then sequences
// for credit limiting, ring wrap, random traffic and reset with traffic
// in flight.
// -----------------------------------------------------------------------------
module tb_flu_qdr_reader;
    localparam int DW   = 64;
    localparam int SPW  = 3;
    localparam int EPW  = 6;
    localparam int AW   = 6;
    localparam int BI   = 16;
    localparam int W    = DW + SPW + EPW + 2;
    localparam int RING = 1 << AW;
    localparam int LAT  = 6;

    logic          APP_CLK      = 1'b0;
    logic          APP_RST      = 1'b1;
    logic [AW:0]   WR_PTR       = '0;
    logic [AW:0]   RD_PTR;
    logic          QDR_RD_REQ;
    logic [AW-1:0] QDR_RD_ADDR;
    logic          QDR_RD_RDY   = 1'b1;
    logic [W-1:0]  QDR_RD_DATA  = '0;
    logic          QDR_RD_VALID = 1'b0;
    logic [DW-1:0] TX_DATA;
    logic [SPW-1:0] TX_SOP_POS;
    logic [EPW-1:0] TX_EOP_POS;
    logic          TX_SOP;
    logic          TX_EOP;
    logic          TX_SRC_RDY;
    logic          TX_DST_RDY   = 1'b0;

    flu_qdr_reader #(
        .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW),
        .ADDR_WIDTH(AW), .BUF_ITEMS(BI)
    ) dut (
        .APP_CLK(APP_CLK), .APP_RST(APP_RST),
        .WR_PTR(WR_PTR), .RD_PTR(RD_PTR),
        .QDR_RD_REQ(QDR_RD_REQ), .QDR_RD_ADDR(QDR_RD_ADDR), .QDR_RD_RDY(QDR_RD_RDY),
        .QDR_RD_DATA(QDR_RD_DATA), .QDR_RD_VALID(QDR_RD_VALID),
        .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
        .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
    );

    initial forever #5 APP_CLK = ~APP_CLK;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } rsp_t;

    logic [W-1:0]  mem_model [RING];
    logic [W-1:0]  exp_q [$];
    rsp_t          pipe_q [$];
    logic [AW-1:0] addr_log [$];
    int            cyc     = 0;
    int            acc_cnt = 0;
    int            tx_cnt  = 0;
    int            max_out = 0;
    bit            rnd_mode = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [DW-1:0] d, input logic [SPW-1:0] sp,
                                          input logic [EPW-1:0] ep, input logic s, input logic e);
        return {d, sp, ep, s, e};
    endfunction

    task automatic write_word(input logic [AW:0] p, input logic [W-1:0] w);
        mem_model[p[AW-1:0]] = w;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge APP_CLK);
        #1;
        if (rnd_mode) TX_DST_RDY = ($urandom_range(0, 9) < 7);
    endtask

    task automatic wait_rd(input logic [AW:0] target, input int limit, input string name);
        int n;
        n = 0;
        while (RD_PTR !== target && n < limit) begin
            tick();
            n++;
        end
        check(name, RD_PTR, target);
    endtask

    task automatic do_reset();
        APP_RST    = 1'b1;
        WR_PTR     = '0;
        TX_DST_RDY = 1'b0;
        rnd_mode   = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        APP_RST = 1'b0;
    endtask

    // QDR memory model with fixed latency, plus TX scoreboard and credit tracking.
    rsp_t         rsp;
    logic [W-1:0] sb_got;
    logic [W-1:0] sb_exp;
    initial forever begin
        @(negedge APP_CLK);
        cyc++;
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            QDR_RD_VALID = 1'b1;
            QDR_RD_DATA  = pipe_q[0].data;
            void'(pipe_q.pop_front());
        end else begin
            QDR_RD_VALID = 1'b0;
            QDR_RD_DATA  = '0;
        end
        QDR_RD_RDY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (APP_RST) begin
            acc_cnt = 0;
            tx_cnt  = 0;
            addr_log.delete();
        end else begin
            if (QDR_RD_REQ && QDR_RD_RDY) begin
                rsp.due  = cyc + LAT;
                rsp.data = mem_model[QDR_RD_ADDR];
                pipe_q.push_back(rsp);
                addr_log.push_back(QDR_RD_ADDR);
                acc_cnt++;
            end
            if (TX_SRC_RDY && TX_DST_RDY) begin
                tx_cnt++;
                sb_got = {TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP};
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", sb_got, '0);
                    if (sb_got == '0) begin
                        err_cnt++;
                        $display("FAIL sb_unexpected_word: got transfer expected none");
                    end
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_word", sb_got, sb_exp);
                end
            end
            if (acc_cnt - tx_cnt > max_out) max_out = acc_cnt - tx_cnt;
        end
    end

    typedef struct {
        logic [AW:0]    wr_ptr;
        logic           dst_rdy;
        logic           exp_req;
        logic           chk_addr;
        logic [AW-1:0]  exp_addr;
        logic           exp_src;
        logic [AW:0]    exp_rd_ptr;
        logic           chk_tx;
        logic [DW-1:0]  exp_data;
        logic [SPW-1:0] exp_sop_pos;
        logic [EPW-1:0] exp_eop_pos;
        logic           exp_sop;
        logic           exp_eop;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic req, input logic ca, input logic [AW-1:0] addr,
                                input logic src, input logic [AW:0] rdp, input logic ct,
                                input logic [DW-1:0] d, input logic [SPW-1:0] sp,
                                input logic [EPW-1:0] ep, input logic s, input logic e);
        vec_t v;
        v.wr_ptr = 7'd3;  v.dst_rdy = 1'b1;
        v.exp_req = req;  v.chk_addr = ca; v.exp_addr = addr;
        v.exp_src = src;  v.exp_rd_ptr = rdp;
        v.chk_tx = ct;    v.exp_data = d; v.exp_sop_pos = sp; v.exp_eop_pos = ep;
        v.exp_sop = s;    v.exp_eop = e;
        return v;
    endfunction

    localparam logic [DW-1:0] D0 = 64'h1111_0000_AAAA_0001;
    localparam logic [DW-1:0] D1 = 64'h2222_0000_BBBB_0002;
    localparam logic [DW-1:0] D2 = 64'h3333_0000_CCCC_0003;

    logic [AW:0]    wp;
    logic [AW:0]    used;
    logic [DW-1:0]  rd;
    logic [SPW-1:0] rsp_pos;
    logic [EPW-1:0] rep_pos;
    int             flen;
    int             n;

    initial begin
        // Per-cycle expectations for one 3-word frame, latency 6, RDY and DST_RDY high.
        vecs[0]  = mk(1'b1, 1'b1, 6'd0, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 6'd1, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 6'd2, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 6'd0, 1'b1, 7'd0, 1'b1, D0, 3'd2, 6'd0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 6'd0, 1'b1, 7'd1, 1'b1, D1, 3'd0, 6'd0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 6'd0, 1'b1, 7'd2, 1'b1, D2, 3'd0, 6'd37, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 6'd0, 1'b0, 7'd3, 1'b0, '0, 3'd0, 6'd0, 1'b0, 1'b0);

        // Reset state held with an empty ring.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rst_req", QDR_RD_REQ, 1'b0);
            check("rst_src_rdy", TX_SRC_RDY, 1'b0);
            check("rst_rd_ptr", RD_PTR, 7'd0);
        end

        // Single frame through the table.
        write_word(7'd0, pack(D0, 3'd2, 6'd0, 1'b1, 1'b0));
        write_word(7'd1, pack(D1, 3'd0, 6'd0, 1'b0, 1'b0));
        write_word(7'd2, pack(D2, 3'd0, 6'd37, 1'b0, 1'b1));
        for (int i = 0; i < NV; i++) begin
            tick();
            WR_PTR     = vecs[i].wr_ptr;
            TX_DST_RDY = vecs[i].dst_rdy;
            #1;
            check($sformatf("v%0d_req", i), QDR_RD_REQ, vecs[i].exp_req);
            if (vecs[i].chk_addr) check($sformatf("v%0d_addr", i), QDR_RD_ADDR, vecs[i].exp_addr);
            check($sformatf("v%0d_src_rdy", i), TX_SRC_RDY, vecs[i].exp_src);
            check($sformatf("v%0d_rd_ptr", i), RD_PTR, vecs[i].exp_rd_ptr);
            if (vecs[i].chk_tx) begin
                check($sformatf("v%0d_data", i), TX_DATA, vecs[i].exp_data);
                check($sformatf("v%0d_sop_pos", i), TX_SOP_POS, vecs[i].exp_sop_pos);
                check($sformatf("v%0d_eop_pos", i), TX_EOP_POS, vecs[i].exp_eop_pos);
                check($sformatf("v%0d_sop", i), TX_SOP, vecs[i].exp_sop);
                check($sformatf("v%0d_eop", i), TX_EOP, vecs[i].exp_eop);
            end
        end
        check("frame_drained", exp_q.size(), 0);

        // Credit limit: TX stalled, 40 words available, only BUF_ITEMS may be fetched.
        do_reset();
        for (int i = 0; i < 40; i++)
            write_word(7'(i), pack({$urandom, $urandom}, 3'(i), 6'(i), 1'(i % 2), 1'(i % 3 == 0)));
        WR_PTR = 7'd40;
        repeat (40) tick();
        check("credit_requests", acc_cnt, BI);
        check("credit_req_low", QDR_RD_REQ, 1'b0);
        check("credit_src_rdy", TX_SRC_RDY, 1'b1);
        check("credit_rd_ptr", RD_PTR, 7'd0);
        TX_DST_RDY = 1'b1;
        wait_rd(7'd40, 300, "credit_release_rd_ptr");
        tick();
        check("credit_total_requests", acc_cnt, 40);
        check("credit_end_req", QDR_RD_REQ, 1'b0);
        check("credit_end_src_rdy", TX_SRC_RDY, 1'b0);
        check("credit_drained", exp_q.size(), 0);

        // Ring wrap: advance to 62, then read across the end of the ring.
        do_reset();
        for (int i = 0; i < 62; i++)
            write_word(7'(i), pack({$urandom, $urandom}, 3'd0, 6'd0, 1'b1, 1'b1));
        WR_PTR     = 7'd62;
        TX_DST_RDY = 1'b1;
        wait_rd(7'd62, 400, "wrap_prefill_rd_ptr");
        tick();
        addr_log.delete();
        for (int i = 62; i < 66; i++)
            write_word(7'(i), pack({$urandom, $urandom}, 3'(i), 6'(i), 1'b0, 1'b0));
        WR_PTR = 7'd66;
        wait_rd(7'd66, 100, "wrap_rd_ptr");
        check("wrap_addr_count", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("wrap_addr0", addr_log[0], 6'd62);
            check("wrap_addr1", addr_log[1], 6'd63);
            check("wrap_addr2", addr_log[2], 6'd0);
            check("wrap_addr3", addr_log[3], 6'd1);
        end
        check("wrap_msb", RD_PTR[AW], 1'b1);
        tick();
        check("wrap_empty_req", QDR_RD_REQ, 1'b0);
        check("wrap_empty_src_rdy", TX_SRC_RDY, 1'b0);
        check("wrap_drained", exp_q.size(), 0);

        // Random frames with random RDY / DST_RDY, writer respecting ring space.
        do_reset();
        rnd_mode = 1'b1;
        wp = '0;
        for (int f = 0; f < 1000; f++) begin
            flen = $urandom_range(1, 4);
            n = 0;
            used = wp - RD_PTR;
            while (int'(used) + flen > RING && n < 2000) begin
                tick();
                used = wp - RD_PTR;
                n++;
            end
            if (n >= 2000) check("rand_space_timeout", n, 0);
            for (int i = 0; i < flen; i++) begin
                rd      = {$urandom, $urandom};
                rsp_pos = (i == 0) ? SPW'($urandom_range(0, 7)) : '0;
                rep_pos = (i == flen - 1) ? EPW'($urandom_range(0, 63)) : '0;
                write_word(wp, pack(rd, rsp_pos, rep_pos, 1'(i == 0), 1'(i == flen - 1)));
                wp = wp + 7'd1;
            end
            WR_PTR = wp;
            tick();
        end
        wait_rd(wp, 6000, "rand_rd_ptr");
        rnd_mode   = 1'b0;
        TX_DST_RDY = 1'b0;
        tick();
        check("rand_drained", exp_q.size(), 0);
        check("rand_credit_max_ok", (max_out <= BI), 1'b1);

        // Reset with 5 reads in flight and 4 words buffered.
        for (int i = 0; i < 9; i++) write_word(wp + 7'(i), pack({$urandom, $urandom}, 3'd1, 6'd1, 1'b1, 1'b1));
        WR_PTR = wp + 7'd9;
        repeat (10) tick();
        check("mid_src_rdy", TX_SRC_RDY, 1'b1);
        check("mid_rd_ptr", RD_PTR, wp);
        APP_RST = 1'b1;
        WR_PTR  = '0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("inrst_src_rdy", TX_SRC_RDY, 1'b0);
            check("inrst_rd_ptr", RD_PTR, 7'd0);
            check("inrst_req", QDR_RD_REQ, 1'b0);
        end
        APP_RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("postrst_src_rdy", TX_SRC_RDY, 1'b0);
            check("postrst_rd_ptr", RD_PTR, 7'd0);
            check("postrst_req", QDR_RD_REQ, 1'b0);
        end
        write_word(7'd0, pack(64'hDEAD_BEEF_0000_0001, 3'd5, 6'd0, 1'b1, 1'b0));
        write_word(7'd1, pack(64'hDEAD_BEEF_0000_0002, 3'd0, 6'd0, 1'b0, 1'b0));
        write_word(7'd2, pack(64'hDEAD_BEEF_0000_0003, 3'd0, 6'd12, 1'b0, 1'b1));
        WR_PTR     = 7'd3;
        TX_DST_RDY = 1'b1;
        wait_rd(7'd3, 100, "postrst_traffic_rd_ptr");
        tick();
        check("postrst_drained", exp_q.size(), 0);
        check("postrst_requests", acc_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
